// File: rtl/toggle_counter_pkg.sv
// toggle_counter_pkg: shared mode constants and the MAX_VAL range helper for toggle_counter
package toggle_counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  function automatic int max_count(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/toggle_counter_cell.sv
// toggle_cell: single-bit T flip-flop with async active-low reset; ports clk, rst_n, t (toggle), q (state)
module toggle_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);
  logic q_d, q_q;
  always_comb q_d = q_q ^ t;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 1'b0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/toggle_counter.sv
// toggle_counter: up/down modulo counter of toggle cells; ports clk, rst_n, clear, load, d, en, up -> q, tc (comb), wrap (registered pulse)
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam int BOUND = max_count(WIDTH);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam bit SAT = (SATURATE == MODE_SAT);
  if (MAX_VAL < 1 || MAX_VAL > BOUND) begin : g_bad_max
    $error("toggle_counter: MAX_VAL out of range 1..2**WIDTH-1");
  end
  logic [WIDTH-1:0] nq, t;
  logic at_max, at_zero, edge_hit, wrap_d, wrap_q;
  always_comb begin
    at_max   = (q == MAX);
    at_zero  = (q == '0);
    edge_hit = up ? at_max : at_zero;
    nq = clear ? '0 :
         load  ? ((d > MAX) ? MAX : d) :
         !en   ? q :
         up    ? (at_max  ? (SAT ? q : '0)  : q + WIDTH'(1)) :
                 (at_zero ? (SAT ? q : MAX) : q - WIDTH'(1));
    // clear/load reach the cells as toggles too, so every bit is a plain T flop
    t      = q ^ nq;
    wrap_d = !clear && !load && en && !SAT && edge_hit;
    tc     = en && edge_hit;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell u_cell (.clk(clk), .rst_n(rst_n), .t(t[i]), .q(q[i]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: table, corner-case and random checks of three toggle_counter configurations against a reference model
module tb_toggle_counter;
  logic clk = 0, rst_n = 0, clear = 0, load = 0, en = 1, up = 1;
  logic [3:0] d = 0;
  logic [3:0] qo [3];
  logic tco [3], wro [3];
  int checks = 0, errors = 0;
  int mq [3];
  bit mw [3];
  localparam int MV [3] = '{9, 9, 15};
  localparam bit MS [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_a (.clk(clk), .rst_n(rst_n), .clear(clear),
    .load(load), .d(d), .en(en), .up(up), .q(qo[0]), .tc(tco[0]), .wrap(wro[0]));
  toggle_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_b (.clk(clk), .rst_n(rst_n), .clear(clear),
    .load(load), .d(d), .en(en), .up(up), .q(qo[1]), .tc(tco[1]), .wrap(wro[1]));
  toggle_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0)) u_c (.clk(clk), .rst_n(rst_n), .clear(clear),
    .load(load), .d(d), .en(en), .up(up), .q(qo[2]), .tc(tco[2]), .wrap(wro[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int m, nx;
      bit w;
      m = MV[i];
      w = 0;
      if (!rst_n) nx = 0;
      else if (clear) nx = 0;
      else if (load) nx = (int'(d) > m) ? m : int'(d);
      else if (!en) nx = mq[i];
      else if (up) begin
        nx = MS[i] ? ((mq[i] + 1 > m) ? m : mq[i] + 1) : (mq[i] + 1) % (m + 1);
        w = !MS[i] && mq[i] == m;
      end else begin
        nx = MS[i] ? ((mq[i] == 0) ? 0 : mq[i] - 1) : (mq[i] + m) % (m + 1);
        w = !MS[i] && mq[i] == 0;
      end
      mq[i] = nx;
      mw[i] = w;
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      bit etc;
      etc = en && ((up && mq[i] == MV[i]) || (!up && mq[i] == 0));
      chk($sformatf("%s_q%0d", tag, i), int'(qo[i]), mq[i]);
      chk($sformatf("%s_wrap%0d", tag, i), int'(wro[i]), int'(mw[i]));
      chk($sformatf("%s_tc%0d", tag, i), int'(tco[i]), int'(etc));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic set_in(input bit c, input bit l, input int dv, input bit e, input bit u);
    clear = c; load = l; d = 4'(dv); en = e; up = u;
  endtask

  typedef struct {
    bit c, l; int dv; bit e, u;
    int eq; bit etc, ew;
  } vec_t;
  vec_t tv [$];

  initial begin
    int wraps;
    for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 0; end
    for (int i = 0; i < 3; i++) begin
      tick("rst");
      chk("rst_q", int'(qo[0]), 0);
      chk("rst_wrap", int'(wro[0]), 0);
    end
    rst_n = 1;
    for (int k = 1; k <= 9; k++) tv.push_back('{0, 0, 0, 1, 1, k, k == 9, 0});
    tv.push_back('{0, 0, 0, 1, 1, 0, 0, 1});
    tv.push_back('{0, 0, 0, 1, 1, 1, 0, 0});
    tv.push_back('{0, 1, 2, 0, 0, 2, 0, 0});
    tv.push_back('{0, 0, 0, 1, 0, 1, 0, 0});
    tv.push_back('{0, 0, 0, 1, 0, 0, 1, 0});
    tv.push_back('{0, 0, 0, 1, 0, 9, 0, 1});
    tv.push_back('{0, 0, 0, 1, 1, 0, 0, 1});
    tv.push_back('{0, 1, 15, 0, 1, 9, 0, 0});
    tv.push_back('{1, 1, 4, 1, 1, 0, 0, 0});
    tv.push_back('{0, 1, 3, 1, 1, 3, 0, 0});
    foreach (tv[i]) begin
      set_in(tv[i].c, tv[i].l, tv[i].dv, tv[i].e, tv[i].u);
      tick("tbl");
      chk($sformatf("tbl%0d_q", i), int'(qo[0]), tv[i].eq);
      chk($sformatf("tbl%0d_tc", i), int'(tco[0]), int'(tv[i].etc));
      chk($sformatf("tbl%0d_wrap", i), int'(wro[0]), int'(tv[i].ew));
    end
    // asynchronous reset while q=5, no clock edge in between
    set_in(0, 1, 5, 0, 1);
    tick("ld5");
    chk("pre_arst_q", int'(qo[0]), 5);
    #2 rst_n = 0;
    #1;
    chk("arst_q", int'(qo[0]), 0);
    chk("arst_wrap", int'(wro[0]), 0);
    for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 0; end
    @(negedge clk) rst_n = 1;
    // saturating instance at both boundaries
    set_in(0, 1, 15, 0, 1);
    tick("sat_ld");
    set_in(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick("sat_up");
      chk("sat_hi_q", int'(qo[1]), 9);
      chk("sat_hi_tc", int'(tco[1]), 1);
      chk("sat_hi_wrap", int'(wro[1]), 0);
    end
    set_in(1, 0, 0, 0, 0);
    tick("sat_clr");
    set_in(0, 0, 0, 1, 0);
    tick("sat_dn");
    chk("sat_lo_q", int'(qo[1]), 0);
    chk("sat_lo_wrap", int'(wro[1]), 0);
    // full-range instance: hold, then a complete revolution
    set_in(0, 1, 7, 0, 1);
    tick("hold_ld");
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tick("hold");
      chk("hold_q", int'(qo[2]), 7);
      chk("hold_tc", int'(tco[2]), 0);
    end
    set_in(1, 0, 0, 0, 1);
    tick("full_clr");
    set_in(0, 0, 0, 1, 1);
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      tick("full");
      wraps += int'(wro[2]);
    end
    chk("full_q", int'(qo[2]), 0);
    chk("full_wraps", wraps, 1);
    // random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(15) == 0, $urandom_range(7) == 0, int'($urandom_range(15)),
             $urandom_range(3) != 0, $urandom_range(1) == 1);
      tick("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
